bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Sits directly upstream of the 4-digit seven-segment decoder stage.
//   Takes a binary count (0..9999) and produces packed BCD: digit3 in [15:12] down to digit0 in [3:0].
//   That packed value drives the decoder's 16-bit input directly.
//   Out-of-range values produce nibbles of 4'hF, which the decoder shows as blank digits.
// PARAMETERS
//   BIN_W   14  width of binary input; 14 bits covers 0..9999
//   DIGITS  4   number of BCD digits produced; max representable = 10^DIGITS-1
// PORTS
//   CLOCK_50  in   1          system clock; all logic on rising edge
//   RESET     in   1          synchronous, active-high reset
//   start     in   1          request a conversion of bin_in; sampled only in IDLE
//   bin_in    in   BIN_W      binary value; captured on the accepted start edge
//   busy      out  1          high while in CONV
//   done      out  1          single-cycle pulse when bcd_out/overflow are updated
//   overflow  out  1          last accepted bin_in exceeded 10^DIGITS-1; held until next done
//   bcd_out   out  4*DIGITS   packed BCD result; holds last result between conversions
// BEHAVIOUR
//   - Reset (RESET=1 at a clock edge):
//       state=IDLE, busy=0, done=0, overflow=0, bcd_out=0.
//       Takes priority over all other inputs.
//       A conversion in flight is aborted: no done pulse, bcd_out is cleared.
//   - FSM states:
//       IDLE -> CONV : start=1 and bin_in <= 10^DIGITS-1.
//         Load shift register {bcd=0, bin=bin_in}; bit counter=0.
//       IDLE -> DONE : start=1 and bin_in > 10^DIGITS-1 (overflow path; no CONV cycles).
//       CONV -> CONV : each cycle, first add 3 to every BCD nibble >= 5.
//         Then shift {bcd,bin} left by 1; counter increments.
//       CONV -> DONE : after exactly BIN_W shifts.
//       DONE -> IDLE : unconditionally, next cycle.
//   - Outputs in DONE:
//       Normal path: bcd_out = converted BCD, overflow=0.
//       Overflow path: bcd_out = all nibbles 4'hF, overflow=1.
//       done=1 only in DONE, so it lasts exactly one cycle.
//   - Latency, with the start edge at cycle N:
//       busy=1 in cycles N+1..N+BIN_W.
//       done=1 and new bcd_out visible in cycle N+BIN_W+1.
//       Overflow path: done and new outputs in cycle N+1; busy stays 0.
//   - start is ignored in CONV and DONE: no queueing, and a captured bin_in is never altered.
//   - bcd_out and overflow change only in DONE or on reset.
//   - Arithmetic:
//       Add-3 is per nibble, 4-bit, with no carry between nibbles.
//       The shift register is 4*DIGITS+BIN_W bits wide.
//       Range check compares bin_in against the constant 10^DIGITS-1 (9999 by default), unsigned.
//   - Boundaries:
//       bin_in=0 still takes the full BIN_W cycles.
//       bin_in = max value converts normally.
//       Max value + 1 takes the overflow path.
// TESTING
//   1. RESET, then start with bin_in=0
//      -> busy high for 14 cycles; done pulse at N+15; bcd_out=16'h0000, overflow=0.
//   2. bin_in=9999 -> done at N+15; bcd_out=16'h9999.
//      bin_in=1234 -> 16'h1234.
//      bin_in=5 -> 16'h0005.
//   3. bin_in=10000, then bin_in=16383
//      -> done at N+1; busy never high; bcd_out=16'hFFFF; overflow=1.
//      A following bin_in=42 returns 16'h0042 with overflow=0.
//   4. Convert 1234, then pulse start with bin_in=777 at cycle N+5
//      -> ignored; bcd_out=16'h1234 at N+15; no second done.
//   5. Start 8888; result 16'h0042 still held; assert RESET at N+7
//      -> next cycle busy=0, bcd_out=0, no done at N+15.
//      A following start with 31 gives 16'h0031.
//   6. Back-to-back requests with start held high continuously
//      -> a new conversion is accepted on the first IDLE cycle after each done.
//      done pulses are 16 cycles apart, and each result matches its bin_in.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq_if
//   Request/result bundle between a producer of binary counts and the
//   sequential binary-to-BCD converter.
//
//   Signals
//     start     producer -> converter  request a conversion of bin_in
//     bin_in    producer -> converter  binary value, BIN_W bits
//     busy      converter -> producer  high while the converter is shifting
//     done      converter -> producer  one-cycle pulse when results update
//     overflow  converter -> producer  last accepted value was out of range
//     bcd_out   converter -> producer  packed BCD, digit0 in [3:0]
//
//   Modports
//     master  drives start/bin_in, observes results
//     slave   the converter side
// ----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) ();

    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  overflow,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output overflow,
        output bcd_out
    );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
//   Feeds the packed BCD result straight into a 4-digit seven-segment decoder.
//   Values above 10^DIGITS-1 skip the conversion and report all-F nibbles,
//   which the decoder renders as blank digits.
//
//   Ports
//     CLOCK_50  system clock, rising edge
//     RESET     synchronous active-high reset, aborts any conversion
//     conv      slave side of bin_to_bcd_seq_if:
//                 start/bin_in  request (sampled only while idle)
//                 busy          high for the BIN_W shift cycles
//                 done          one-cycle pulse when bcd_out/overflow update
//                 overflow      last accepted value exceeded 10^DIGITS-1
//                 bcd_out       packed BCD, held between conversions
//
//   Timing (start accepted at the edge ending cycle N)
//     in range : busy in N+1..N+BIN_W, done in N+BIN_W+1
//     overflow : done in N+1, busy never asserted
// ----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    bin_to_bcd_seq_if.slave       conv
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned SrW  = BcdW + BIN_W;
    localparam int unsigned CntW = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned MaxVal  = pow10(DIGITS) - 64'd1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e             state_q;
    logic [SrW-1:0]     sr_q;       // {bcd digits, remaining binary bits}
    logic [CntW-1:0]    cnt_q;      // shifts already performed
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic [BcdW-1:0]    bcd_q;

    // ------------------------------------------------------------------------
    // Datapath: one double-dabble step on the current shift register
    // ------------------------------------------------------------------------
    logic [SrW-1:0]     sr_adj;
    logic [SrW-1:0]     sr_shift;
    logic               in_range;

    always_comb begin
        sr_adj = sr_q;
        // Each nibble is corrected independently; a nibble >= 5 would become
        // >= 10 after the shift, so pre-adding 3 makes it carry out as BCD.
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (sr_q[BIN_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*d +: 4] = sr_q[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[SrW-2:0], 1'b0};
    end

    assign in_range = (64'(conv.bin_in) <= MaxVal);

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (conv.start) begin
                        if (in_range) begin
                            sr_q    <= {{BcdW{1'b0}}, conv.bin_in};
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StConv;
                        end else begin
                            // Out of range: publish blanks immediately.
                            bcd_q   <= '1;
                            ovf_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end

                StConv: begin
                    sr_q  <= sr_shift;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        // Final shift: take the result from the shifted value so
                        // it appears in the same cycle as done.
                        bcd_q   <= sr_shift[SrW-1 -: BcdW];
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end

                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign conv.busy     = busy_q;
    assign conv.done     = done_q;
    assign conv.overflow = ovf_q;
    assign conv.bcd_out  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: vector table, random values against a decimal
// reference model, and hand-written multi-cycle sequences.
module tb_bin_to_bcd_seq;

    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned LAT    = BIN_W + 1;

    logic clk;
    logic rst;

    int n_cmp  = 0;
    int n_fail = 0;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) conv_if ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .conv     (conv_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic [15:0]      bcd;
        logic             ovf;
        int               lat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits by plain division, blanks above 9999.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned t;
        if (v > 9999) return 16'hFFFF;
        r = '0;
        t = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // One start pulse, then watch until well past the expected done cycle.
    // bin_in is scrambled after acceptance to show the capture is held.
    task automatic do_conv(input logic [BIN_W-1:0] v, input logic [15:0] eb,
                           input logic eo, input int elat, input string tag);
        int busy_cnt;
        int done_cyc;
        int done_cnt;
        logic [15:0] got_bcd;
        logic got_ovf;
        busy_cnt = 0;
        done_cyc = 0;
        done_cnt = 0;
        got_bcd  = '0;
        got_ovf  = 1'b0;
        conv_if.start  = 1'b1;
        conv_if.bin_in = v;
        tick();
        conv_if.start  = 1'b0;
        conv_if.bin_in = BIN_W'($urandom);
        for (int c = 1; c <= elat + 3; c++) begin
            if (conv_if.busy) busy_cnt++;
            if (conv_if.done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    got_bcd  = conv_if.bcd_out;
                    got_ovf  = conv_if.overflow;
                end
            end
            if (c < elat + 3) tick();
        end
        chk({tag, " done_cycle"}, done_cyc, elat);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " busy_cycles"}, busy_cnt, (elat == 1) ? 0 : BIN_W);
        chk({tag, " bcd"}, got_bcd, eb);
        chk({tag, " overflow"}, got_ovf, eo);
        chk({tag, " bcd_held"}, conv_if.bcd_out, eb);
    endtask

    initial begin
        logic [BIN_W-1:0] v;
        logic [BIN_W-1:0] bb[4];
        int dc[4];
        logic [15:0] res[4];
        int k;
        int done_cnt;

        vecs[0] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0, lat: LAT};
        vecs[1] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0, lat: LAT};
        vecs[2] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0, lat: LAT};
        vecs[3] = '{bin: 14'd5,     bcd: 16'h0005, ovf: 1'b0, lat: LAT};
        vecs[4] = '{bin: 14'd10000, bcd: 16'hFFFF, ovf: 1'b1, lat: 1};
        vecs[5] = '{bin: 14'd16383, bcd: 16'hFFFF, ovf: 1'b1, lat: 1};
        vecs[6] = '{bin: 14'd42,    bcd: 16'h0042, ovf: 1'b0, lat: LAT};
        vecs[7] = '{bin: 14'd8050,  bcd: 16'h8050, ovf: 1'b0, lat: LAT};

        // Reset state
        rst = 1'b1;
        conv_if.start  = 1'b0;
        conv_if.bin_in = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", conv_if.busy, 0);
        chk("reset done", conv_if.done, 0);
        chk("reset overflow", conv_if.overflow, 0);
        chk("reset bcd", conv_if.bcd_out, 16'h0000);
        tick();

        // Vector table
        for (int i = 0; i < 8; i++) begin
            do_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, vecs[i].lat,
                    $sformatf("vec%0d(%0d)", i, vecs[i].bin));
        end

        // Randomized against the decimal model
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 3) v = BIN_W'($urandom_range(10000, 16383));
            else            v = BIN_W'($urandom_range(0, 9999));
            do_conv(v, ref_bcd(v), (v > 9999), (v > 9999) ? 1 : LAT,
                    $sformatf("rnd%0d(%0d)", i, v));
        end

        // start during CONV is ignored
        conv_if.start  = 1'b1;
        conv_if.bin_in = 14'd1234;
        tick();                                // cycle N+1
        conv_if.start  = 1'b0;
        for (int c = 1; c < 5; c++) tick();    // cycle N+5
        conv_if.start  = 1'b1;
        conv_if.bin_in = 14'd777;
        tick();
        conv_if.start  = 1'b0;
        done_cnt = 0;
        k = 0;
        for (int c = 6; c <= 34; c++) begin
            if (conv_if.done) begin
                done_cnt++;
                if (k == 0) k = c;
            end
            tick();
        end
        chk("ignore done_cycle", k, LAT);
        chk("ignore done_count", done_cnt, 1);
        chk("ignore bcd", conv_if.bcd_out, 16'h1234);

        // Reset mid-conversion
        do_conv(14'd42, 16'h0042, 1'b0, LAT, "pre42");
        conv_if.start  = 1'b1;
        conv_if.bin_in = 14'd8888;
        tick();                                // N+1
        conv_if.start  = 1'b0;
        for (int c = 1; c < 7; c++) tick();    // N+7
        chk("abort busy_before", conv_if.busy, 1);
        chk("abort bcd_before", conv_if.bcd_out, 16'h0042);
        rst = 1'b1;
        tick();                                // N+8
        rst = 1'b0;
        chk("abort busy", conv_if.busy, 0);
        chk("abort bcd", conv_if.bcd_out, 16'h0000);
        done_cnt = 0;
        for (int c = 8; c <= 20; c++) begin
            if (conv_if.done) done_cnt++;
            tick();
        end
        chk("abort no_done", done_cnt, 0);
        chk("abort bcd_after", conv_if.bcd_out, 16'h0000);
        do_conv(14'd31, 16'h0031, 1'b0, LAT, "post31");

        // Back-to-back with start held high
        for (int i = 0; i < 4; i++) begin
            bb[i] = BIN_W'($urandom_range(0, 9999));
            dc[i] = 0;
            res[i] = '0;
        end
        k = 0;
        conv_if.start  = 1'b1;
        conv_if.bin_in = bb[0];
        tick();                                // cycle 1
        for (int c = 1; c <= 63; c++) begin
            if (conv_if.done && k < 4) begin
                dc[k]  = c;
                res[k] = conv_if.bcd_out;
                k++;
                if (k < 4) conv_if.bin_in = bb[k];
            end
            tick();
        end
        conv_if.start = 1'b0;
        done_cnt = 0;
        for (int c = 64; c <= 84; c++) begin
            if (conv_if.done) done_cnt++;
            tick();
        end
        chk("b2b count", k, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b%0d done_cycle", i), dc[i], LAT + 16 * i);
            chk($sformatf("b2b%0d bcd", i), res[i], ref_bcd(bb[i]));
        end
        chk("b2b drained", done_cnt, 0);
        chk("b2b idle busy", conv_if.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
